// File: rtl/launcher_pkg.sv
// ---------------------------------------------------------------------------
// launcher_pkg : shared types and widths for the slingshot launcher
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package launcher_pkg;

  localparam int POWER_W = 11;
  localparam int BIRDS_W = 3;

  typedef enum logic [2:0] {
    READY   = 3'd0,
    CHARGE  = 3'd1,
    FIRE    = 3'd2,
    WAIT_ON = 3'd3,
    FLIGHT  = 3'd4,
    EMPTY   = 3'd5
  } launcher_st_t;

endpackage

`default_nettype wire

// File: rtl/power_ramp.sv
// ---------------------------------------------------------------------------
// power_ramp : launch power register with step/clamp and 0..15 power bar
// Optional   : LAUNCHER_PINGPONG_EN selects an up/down ramp between limits
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module power_ramp
  import launcher_pkg::*;
#(
  parameter int MIN_POWER  = 8,
  parameter int MAX_POWER  = 120,
  parameter int POWER_STEP = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               step_en,
  output logic [POWER_W-1:0] power,
  output logic [3:0]         power_level
);

  localparam int RANGE = MAX_POWER - MIN_POWER;

  logic [POWER_W-1:0] power_q, power_d;
  logic [3:0]         power_level_q, power_level_d;
  logic [POWER_W:0]   sum_up;
  logic [31:0]        scaled;

  assign sum_up = {1'b0, power_q} + (POWER_W + 1)'(POWER_STEP);

`ifdef LAUNCHER_PINGPONG_EN
  logic dir_down_q, dir_down_d;

  always_comb begin
    power_d    = power_q;
    dir_down_d = dir_down_q;
    if (clear) begin
      power_d    = POWER_W'(MIN_POWER);
      dir_down_d = 1'b0;
    end else if (step_en) begin
      if (!dir_down_q) begin
        if (sum_up >= (POWER_W + 1)'(MAX_POWER)) begin
          power_d    = POWER_W'(MAX_POWER);
          dir_down_d = 1'b1;
        end else begin
          power_d = sum_up[POWER_W-1:0];
        end
      end else begin
        if (power_q <= POWER_W'(MIN_POWER + POWER_STEP)) begin
          power_d    = POWER_W'(MIN_POWER);
          dir_down_d = 1'b0;
        end else begin
          power_d = power_q - POWER_W'(POWER_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) dir_down_q <= 1'b0;
    else         dir_down_q <= dir_down_d;
  end
`else
  always_comb begin
    power_d = power_q;
    if (clear) begin
      power_d = POWER_W'(MIN_POWER);
    end else if (step_en) begin
      if (sum_up >= (POWER_W + 1)'(MAX_POWER)) power_d = POWER_W'(MAX_POWER);
      else                                     power_d = sum_up[POWER_W-1:0];
    end
  end
`endif

  // Floor of (power-MIN)*15/RANGE via compares against constant thresholds.
  always_comb begin
    scaled        = (32'(power_q) - 32'(MIN_POWER)) * 32'd15;
    power_level_d = 4'd0;
    for (int k = 1; k <= 15; k++) begin
      if (scaled >= 32'(k * RANGE)) power_level_d = 4'(k);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      power_q       <= POWER_W'(MIN_POWER);
      power_level_q <= 4'd0;
    end else begin
      power_q       <= power_d;
      power_level_q <= power_level_d;
    end
  end

  assign power       = power_q;
  assign power_level = power_level_q;

endmodule

`default_nettype wire

// File: rtl/slingshot_launcher.sv
// ---------------------------------------------------------------------------
// slingshot_launcher : charge-and-release launch FSM with per-level bird count
// Optional           : LAUNCHER_PINGPONG_EN (up/down power ramp in power_ramp)
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module slingshot_launcher
  import launcher_pkg::*;
#(
  parameter int NUM_BIRDS      = 3,
  parameter int MIN_POWER      = 8,
  parameter int MAX_POWER      = 120,
  parameter int POWER_STEP     = 4,
  parameter int ENROLL_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               charge_key,
  input  logic               enroll,
  input  logic               new_level,
  output logic [POWER_W-1:0] launch_speed,
  output logic               fire_the_bird,
  output logic [3:0]         power_level,
  output logic [BIRDS_W-1:0] birds_left,
  output logic               launcher_busy
);

  localparam int TIMER_W = $clog2(ENROLL_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ENROLL_TIMEOUT - 1);

  launcher_st_t       state_q, state_d;
  logic [BIRDS_W-1:0] birds_q, birds_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               key_armed_q, key_armed_d;
  logic               pending_q, pending_d;
  logic [POWER_W-1:0] speed_q, speed_d;
  logic               fire_q, fire_d;
  logic               busy_q, busy_d;
  logic               ramp_clear, ramp_step;
  logic [POWER_W-1:0] power;
  logic [3:0]         power_level_w;

  power_ramp #(
    .MIN_POWER  (MIN_POWER),
    .MAX_POWER  (MAX_POWER),
    .POWER_STEP (POWER_STEP)
  ) u_power_ramp (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (ramp_clear),
    .step_en     (ramp_step),
    .power       (power),
    .power_level (power_level_w)
  );

  always_comb begin
    state_d     = state_q;
    birds_d     = birds_q;
    timer_d     = timer_q;
    key_armed_d = key_armed_q;
    pending_d   = pending_q;
    speed_d     = speed_q;
    ramp_clear  = 1'b0;
    ramp_step   = 1'b0;

    // Presses seen outside READY disarm, so a key held across a flight cannot start a charge.
    if (!charge_key)             key_armed_d = 1'b1;
    else if (state_q != READY)   key_armed_d = 1'b0;

    if (new_level) pending_d = 1'b1;

    case (state_q)
      READY: begin
        if (new_level) begin
          birds_d   = BIRDS_W'(NUM_BIRDS);
          pending_d = 1'b0;
        end else if (birds_q == '0) begin
          state_d = EMPTY;
        end else if (charge_key && key_armed_q) begin
          state_d     = CHARGE;
          ramp_clear  = 1'b1;
          key_armed_d = 1'b0;
        end
      end
      CHARGE: begin
        if (!charge_key)       state_d   = FIRE;
        else if (startOfFrame) ramp_step = 1'b1;
      end
      FIRE: begin
        birds_d = birds_q - 1'b1;
        timer_d = '0;
        state_d = WAIT_ON;
      end
      WAIT_ON: begin
        if (enroll) begin
          state_d = FLIGHT;
        end else if (startOfFrame) begin
          if (timer_q == TIMER_LAST) begin
            state_d = READY;
            birds_d = birds_q + 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      FLIGHT: begin
        if (!enroll) state_d = (birds_q == '0) ? EMPTY : READY;
      end
      EMPTY: begin
        if (new_level) begin
          state_d   = READY;
          birds_d   = BIRDS_W'(NUM_BIRDS);
          pending_d = 1'b0;
        end
      end
      default: state_d = READY;
    endcase

    // A reload deferred during a shot lands as the FSM returns to idle, overriding any refund.
    if ((state_q == WAIT_ON || state_q == FLIGHT) &&
        (state_d == READY || state_d == EMPTY) && (pending_q || new_level)) begin
      state_d   = READY;
      birds_d   = BIRDS_W'(NUM_BIRDS);
      pending_d = 1'b0;
    end

    if (state_q == CHARGE && state_d == FIRE) speed_d = power;

    fire_d = (state_d == FIRE);
    busy_d = (state_d != READY);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= READY;
      birds_q     <= BIRDS_W'(NUM_BIRDS);
      timer_q     <= '0;
      key_armed_q <= 1'b0;
      pending_q   <= 1'b0;
      speed_q     <= POWER_W'(MIN_POWER);
      fire_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      birds_q     <= birds_d;
      timer_q     <= timer_d;
      key_armed_q <= key_armed_d;
      pending_q   <= pending_d;
      speed_q     <= speed_d;
      fire_q      <= fire_d;
      busy_q      <= busy_d;
    end
  end

  assign launch_speed  = speed_q;
  assign fire_the_bird = fire_q;
  assign power_level   = power_level_w;
  assign birds_left    = birds_q;
  assign launcher_busy = busy_q;

endmodule

`default_nettype wire
